sd_solver_param: RTL and testbench

- Parametrised backtracking Sudoku solver for boards of BOX*BOX cells per side, e.g. 4x4 or 9x9.
- Loads a board one cell per cycle in row-major order, then solves it with a one-blank-per-cycle depth-first search.
- Streams the filled blank values out in row-major blank order.
- Adds explicit error reporting for illegal clues, unsolvable boards and blank-count overflow, plus a busy flag, so upstream can hold off the next puzzle.

---
 rtl/sd_solver_param.sv | 251 +++++++++++++++++++++++++
 tb/tb_sd_solver_param.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_solver_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sd_solver_param
// Purpose  : Parametrised backtracking Sudoku solver (N = BOX*BOX per side).
//            Loads N*N cells row-major, checks the clues, runs a depth-first
//            search that updates one blank per cycle, then streams the filled
//            blank values in row-major blank order.
// Ports    : clk       - rising-edge clock
//            rst_n     - asynchronous active-low reset
//            in_valid  - one cell accepted per high cycle (IDLE/LOAD only)
//            in        - cell value, 0 = blank, 1..N = clue
//            out_valid - qualifies out
//            out       - solved blank value, N+1 = error, 0 = empty marker
//            busy      - high from CHECK through the last out_valid cycle
// Revision : 1.0 - initial release
// ============================================================================
module sd_solver_param #(
    parameter int BOX       = 3,
    parameter int CELL_W    = 4,
    parameter int MAX_BLANK = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [CELL_W-1:0] in,
    output logic              out_valid,
    output logic [CELL_W-1:0] out,
    output logic              busy
);
    localparam int N     = BOX * BOX;
    localparam int NN    = N * N;
    localparam int IDX_W = $clog2(NN);
    localparam int CNT_W = $clog2(NN + 1);
    localparam int RC_W  = $clog2(N);
    localparam int BI_W  = $clog2(MAX_BLANK);
    localparam int BC_W  = $clog2(MAX_BLANK + 1);
    localparam int CUR_W = BC_W + 1;          // one extra bit so -1 is representable
    localparam int MW    = 1 << CELL_W;       // value masks indexed directly by a cell

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_FWD   = 3'd3;
    localparam logic [2:0] S_BWD   = 3'd4;
    localparam logic [2:0] S_OUT   = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;

    logic [2:0]        state, next_state;
    logic [CELL_W-1:0] board     [NN];
    logic [RC_W-1:0]   blank_row [MAX_BLANK];
    logic [RC_W-1:0]   blank_col [MAX_BLANK];
    logic [CNT_W-1:0]  cell_cnt;
    logic [RC_W-1:0]   load_row, load_col;
    logic [BC_W-1:0]   blank_cnt;
    logic              overflow, illegal;
    logic [CUR_W-1:0]  cursor;                // two's complement search cursor
    logic [BI_W-1:0]   out_cnt;

    // The first cell of a puzzle (accepted in IDLE) starts from a clean slate,
    // so the effective load context ignores whatever the last puzzle left.
    logic              accept, first;
    logic [CNT_W-1:0]  eff_cnt;
    logic [RC_W-1:0]   eff_row, eff_col;
    logic [BC_W-1:0]   eff_bc;
    logic              eff_ovf, eff_ill;

    assign first   = (state == S_IDLE);
    assign accept  = in_valid && (first || state == S_LOAD);
    assign eff_cnt = first ? '0 : cell_cnt;
    assign eff_row = first ? '0 : load_row;
    assign eff_col = first ? '0 : load_col;
    assign eff_bc  = first ? '0 : blank_cnt;
    assign eff_ovf = first ? 1'b0 : overflow;
    assign eff_ill = first ? 1'b0 : illegal;

    // Blank under inspection: the search cursor while solving, the output
    // counter while streaming.
    logic [BI_W-1:0]   sel_b;
    logic [RC_W-1:0]   pos_row, pos_col;
    logic [IDX_W-1:0]  pos_idx;

    assign sel_b   = (state == S_OUT) ? out_cnt : cursor[BI_W-1:0];
    assign pos_row = blank_row[sel_b];
    assign pos_col = blank_col[sel_b];
    assign pos_idx = IDX_W'(pos_row) * IDX_W'(N) + IDX_W'(pos_col);

    // Clue consistency: walk the board once, flag any value seen twice in a unit.
    logic [MW-1:0] row_seen [N];
    logic [MW-1:0] col_seen [N];
    logic [MW-1:0] box_seen [N];
    logic          dup;

    always_comb begin
        dup = 1'b0;
        for (int u = 0; u < N; u++) begin
            row_seen[u] = '0;
            col_seen[u] = '0;
            box_seen[u] = '0;
        end
        for (int k = 0; k < NN; k++) begin
            if (board[k] != '0) begin
                if (row_seen[k / N][board[k]] || col_seen[k % N][board[k]] ||
                    box_seen[((k / N) / BOX) * BOX + (k % N) / BOX][board[k]])
                    dup = 1'b1;
                row_seen[k / N][board[k]] = 1'b1;
                col_seen[k % N][board[k]] = 1'b1;
                box_seen[((k / N) / BOX) * BOX + (k % N) / BOX][board[k]] = 1'b1;
            end
        end
    end

    // Candidate search for the cursor cell; the cell itself is left out so its
    // current value never blocks the next candidate.
    logic [MW-1:0]     used;
    logic [CELL_W-1:0] cur_val, cand;
    logic              found;

    always_comb begin
        used = '0;
        for (int k = 0; k < NN; k++) begin
            if ((IDX_W'(k) != pos_idx) &&
                ((RC_W'(k / N) == pos_row) || (RC_W'(k % N) == pos_col) ||
                 ((RC_W'((k / N) / BOX) == pos_row / RC_W'(BOX)) &&
                  (RC_W'((k % N) / BOX) == pos_col / RC_W'(BOX)))))
                used[board[k]] = 1'b1;
        end
        cur_val = board[pos_idx];
        found   = 1'b0;
        cand    = '0;
        for (int v = N; v >= 1; v--) begin
            if ((CELL_W'(v) > cur_val) && !used[v]) begin
                found = 1'b1;
                cand  = CELL_W'(v);
            end
        end
    end

    logic at_last, at_first, out_last;
    assign at_last  = (cursor == CUR_W'(blank_cnt) - CUR_W'(1));
    assign at_first = (cursor == '0);
    assign out_last = (blank_cnt == '0) || (BC_W'(out_cnt) == blank_cnt - BC_W'(1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_LOAD: begin
                if (accept)
                    next_state = (eff_cnt == CNT_W'(NN - 1)) ? S_CHECK : S_LOAD;
            end
            S_CHECK: begin
                if (overflow || illegal || dup) next_state = S_ERR;
                else if (blank_cnt == '0)       next_state = S_OUT;
                else                            next_state = S_FWD;
            end
            S_FWD, S_BWD: begin
                if (found) next_state = at_last  ? S_OUT : S_FWD;
                else       next_state = at_first ? S_ERR : S_BWD;
            end
            S_OUT:   if (out_last) next_state = S_IDLE;
            S_ERR:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        out_valid = 1'b0;
        out       = '0;
        busy      = 1'b0;
        case (state)
            S_CHECK, S_FWD, S_BWD: busy = 1'b1;
            S_OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out       = (blank_cnt == '0) ? '0 : board[pos_idx];
            end
            S_ERR: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out       = CELL_W'(N + 1);
            end
            default: ;
        endcase
    end

    // Datapath: board, blank store, counters and flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NN; i++) board[i] <= '0;
            for (int i = 0; i < MAX_BLANK; i++) begin
                blank_row[i] <= '0;
                blank_col[i] <= '0;
            end
            cell_cnt  <= '0;
            load_row  <= '0;
            load_col  <= '0;
            blank_cnt <= '0;
            overflow  <= 1'b0;
            illegal   <= 1'b0;
            cursor    <= '0;
            out_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE, S_LOAD: begin
                    if (accept) begin
                        board[eff_cnt[IDX_W-1:0]] <= in;
                        cell_cnt <= (eff_cnt == CNT_W'(NN)) ? eff_cnt : eff_cnt + CNT_W'(1);
                        if (eff_col == RC_W'(N - 1)) begin
                            load_col <= '0;
                            load_row <= eff_row + RC_W'(1);
                        end else begin
                            load_col <= eff_col + RC_W'(1);
                            load_row <= eff_row;
                        end
                        blank_cnt <= eff_bc;
                        overflow  <= eff_ovf;
                        illegal   <= eff_ill || (in > CELL_W'(N));
                        if (in == '0) begin
                            if (eff_bc < BC_W'(MAX_BLANK)) begin
                                blank_row[eff_bc[BI_W-1:0]] <= eff_row;
                                blank_col[eff_bc[BI_W-1:0]] <= eff_col;
                                blank_cnt <= eff_bc + BC_W'(1);
                            end else begin
                                overflow <= 1'b1;
                            end
                        end
                    end
                end
                S_CHECK: begin
                    cursor  <= '0;
                    out_cnt <= '0;
                end
                S_FWD, S_BWD: begin
                    board[pos_idx] <= found ? cand : '0;
                    cursor <= found ? cursor + CUR_W'(1) : cursor - CUR_W'(1);
                end
                S_OUT:   out_cnt <= out_cnt + BI_W'(1);
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_sd_solver_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sd_solver_param
// Purpose  : Self-checking bench for sd_solver_param with a BOX=2 and a BOX=3
//            instance. Expected outputs are queued when a puzzle is loaded and
//            popped as the active instance produces out_valid cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sd_solver_param;
    logic       clk = 1'b0;
    logic       rst2_n, rst3_n;
    logic       sel;                  // 0 = BOX=2 instance, 1 = BOX=3 instance
    logic       tb_valid;
    logic [3:0] tb_in;

    logic       iv2, iv3, ov2, ov3, bz2, bz3;
    logic [3:0] o2, o3;
    logic       m_valid, m_busy;
    logic [3:0] m_out;

    int checks   = 0;
    int failures = 0;
    int exp_q [$];
    int cells [81];
    int work  [81];
    string full_s;

    always #5 clk = ~clk;

    assign iv2     = tb_valid & ~sel;
    assign iv3     = tb_valid &  sel;
    assign m_valid = sel ? ov3 : ov2;
    assign m_busy  = sel ? bz3 : bz2;
    assign m_out   = sel ? o3  : o2;

    sd_solver_param #(.BOX(2), .CELL_W(4), .MAX_BLANK(15)) u_dut2 (
        .clk(clk), .rst_n(rst2_n), .in_valid(iv2), .in(tb_in),
        .out_valid(ov2), .out(o2), .busy(bz2)
    );

    sd_solver_param #(.BOX(3), .CELL_W(4), .MAX_BLANK(15)) u_dut3 (
        .clk(clk), .rst_n(rst3_n), .in_valid(iv3), .in(tb_in),
        .out_valid(ov3), .out(o3), .busy(bz3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(obs), $signed(expv));
        end
    endtask

    task automatic set_str(input string s, input int nc);
        for (int i = 0; i < nc; i++) cells[i] = int'(s.getc(i)) - 48;
    endtask

    // Reference search: row-major blanks, smallest legal value first.
    function automatic bit fits(input int n, input int bx, input int p, input int v);
        fits = 1'b1;
        for (int k = 0; k < n * n; k++)
            if (k != p && work[k] == v &&
                (k / n == p / n || k % n == p % n ||
                 ((k / n) / bx == (p / n) / bx && (k % n) / bx == (p % n) / bx)))
                fits = 1'b0;
    endfunction

    task automatic solve_model(input int n, input int bx, output int steps);
        int  bl [$];
        int  cur;
        int  v;
        bit  found;
        for (int k = 0; k < n * n; k++) begin
            work[k] = cells[k];
            if (cells[k] == 0) bl.push_back(k);
        end
        cur   = 0;
        steps = 0;
        while (cur >= 0 && cur < bl.size() && steps < 200000) begin
            found = 1'b0;
            for (v = work[bl[cur]] + 1; v <= n && !found; v++)
                if (fits(n, bx, bl[cur], v)) begin
                    found = 1'b1;
                    work[bl[cur]] = v;
                end
            steps++;
            if (found) cur++;
            else begin
                work[bl[cur]] = 0;
                cur--;
            end
        end
        if (bl.size() == 0)       exp_q.push_back(0);
        else if (cur == bl.size()) foreach (bl[i]) exp_q.push_back(work[bl[i]]);
        else                      exp_q.push_back(n + 1);
    endtask

    task automatic load_cells(input int nc, input int gap);
        for (int i = 0; i < nc; i++) begin
            @(posedge clk); #1;
            tb_valid = 1'b1;
            tb_in    = 4'(cells[i]);
            if (i != nc - 1)
                for (int g = 0; g < gap; g++) begin
                    @(posedge clk); #1;
                    tb_valid = 1'b0;
                end
        end
        @(posedge clk); #1;
        tb_valid = 1'b0;
        tb_in    = '0;
    endtask

    // Called one cycle after the last cell was accepted (t = 1).
    task automatic collect(input string tag, input int exp_lat);
        int t;
        int first_t;
        bit done;
        int expv;
        t       = 1;
        first_t = -1;
        done    = 1'b0;
        while (!done && t < 5000) begin
            @(negedge clk);
            if (t == 1) chk({tag, " busy_rise"}, 32'(m_busy), 1);
            if (m_valid) begin
                if (first_t < 0) first_t = t;
                chk({tag, " pending"}, 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    expv = exp_q.pop_front();
                    chk({tag, " out"}, 32'(m_out), expv);
                end
            end else begin
                chk({tag, " idle_out"}, 32'(m_out), 0);
                if (first_t >= 0) begin
                    done = 1'b1;
                    chk({tag, " busy_fall"}, 32'(m_busy), 0);
                end
            end
            @(posedge clk); #1;
            t++;
        end
        chk({tag, " finished"}, 32'(done), 1);
        chk({tag, " leftover"}, exp_q.size(), 0);
        chk({tag, " latency"}, first_t, exp_lat);
        exp_q.delete();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int steps;
        int seen;
        full_s = "534678912672195348198342567859761423426853791713924856961537284287419635345286179";
        sel = 1'b0; tb_valid = 1'b0; tb_in = '0;
        rst2_n = 1'b0; rst3_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst ov2", 32'(ov2), 0);
        chk("rst bz2", 32'(bz2), 0);
        chk("rst o2",  32'(o2),  0);
        chk("rst ov3", 32'(ov3), 0);
        chk("rst bz3", 32'(bz3), 0);
        chk("rst o3",  32'(o3),  0);
        rst2_n = 1'b1; rst3_n = 1'b1;

        // BOX=2: diagonal blanks, 4 search steps
        set_str("0234301221034320", 16);
        exp_q.push_back(1); exp_q.push_back(4); exp_q.push_back(4); exp_q.push_back(1);
        load_cells(16, 0);
        collect("b2_diag", 6);

        // BOX=2: duplicate clue in row 0
        set_str("1134341221434321", 16);
        exp_q.push_back(5);
        load_cells(16, 0);
        collect("b2_dup", 2);

        // BOX=2: legal clues, cell (0,0) has no candidate
        set_str("0230040010000000", 16);
        exp_q.push_back(5);
        load_cells(16, 0);
        collect("b2_unsolv", 3);

        sel = 1'b1;

        // BOX=3: complete grid -> empty marker, then again with input gaps
        set_str(full_s, 81);
        exp_q.push_back(0);
        load_cells(81, 0);
        collect("b3_full", 2);
        exp_q.push_back(0);
        load_cells(81, 3);
        collect("b3_full_gap", 2);

        // BOX=3: 16 blanks overflow the blank store
        set_str(full_s, 81);
        for (int k = 0; k < 16; k++) cells[k * 5] = 0;
        exp_q.push_back(10);
        load_cells(81, 0);
        collect("b3_ovf", 2);

        // BOX=3: 15 blanks solved against the reference search
        set_str(full_s, 81);
        for (int k = 0; k < 15; k++) cells[k * 5] = 0;
        solve_model(9, 3, steps);
        load_cells(81, 0);
        collect("b3_15", 2 + steps);

        // BOX=3: reset during the search abandons the puzzle
        set_str(full_s, 81);
        for (int k = 0; k < 15; k++) cells[k * 5 + 2] = 0;
        load_cells(81, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_fwd busy", 32'(bz3), 1);
        rst3_n = 1'b0;
        #1;
        chk("async ov3", 32'(ov3), 0);
        chk("async o3",  32'(o3),  0);
        chk("async bz3", 32'(bz3), 0);
        repeat (2) @(posedge clk);
        #1;
        rst3_n = 1'b1;
        seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (ov3 || bz3) seen++;
        end
        chk("post_rst quiet", seen, 0);

        // Fresh puzzle after reset release
        solve_model(9, 3, steps);
        load_cells(81, 0);
        collect("b3_after_rst", 2 + steps);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
